// File: rtl/bcd_bin_conv.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One result bit per clock; start/done handshake with a fixed BIN_W-cycle latency.
module bcd_bin_conv #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // The largest DIGITS-digit decimal value must fit in BIN_W bits.
    generate
        if ((64'd1 << BIN_W) <= (pow10(DIGITS) - 64'd1)) begin : g_width_check
            $error("bcd_bin_conv: BIN_W too small for DIGITS");
        end
    endgenerate

    logic [0:0]       state;
    logic [DW-1:0]    d;
    logic [BIN_W-1:0] b;
    logic [CW-1:0]    cnt;
    logic             invalid;

    logic [DW-1:0]    d_shift;
    logic [DW-1:0]    d_corr;
    logic [BIN_W-1:0] b_shift;
    logic             bcd_bad;

    // Shift {d,b} right one bit, then pull each shifted digit >=8 down by 3.
    always_comb begin
        d_shift = {1'b0, d[DW-1:1]};
        b_shift = {d[0], b[BIN_W-1:1]};
        d_corr  = d_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (d_shift[4*i+3]) d_corr[4*i +: 4] = d_shift[4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin     <= '0;
            err     <= 1'b0;
            d       <= '0;
            b       <= '0;
            cnt     <= '0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d       <= bcd;
                        b       <= '0;
                        invalid <= bcd_bad;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    d   <= d_corr;
                    b   <= b_shift;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(BIN_W - 1)) begin
                        bin   <= invalid ? '0 : b_shift;
                        err   <= invalid;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_bin_conv.sv
// Directed plus randomized bench for bcd_bin_conv against an arithmetic reference.
module tb_bcd_bin_conv;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [11:0]       bcd;
    logic              busy;
    logic              done;
    logic [BIN_W-1:0]  bin;
    logic              err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bcd_bin_conv #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits, or error with zero result.
    task automatic model(input logic [11:0] v, output int exp_bin, output int exp_err);
        int w;
        int dig;
        exp_bin = 0;
        exp_err = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = int'((v >> (4 * i)) & 12'hF);
            if (dig > 9) exp_err = 1;
            exp_bin += dig * w;
            w *= 10;
        end
        if (exp_err != 0) exp_bin = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_conv(input logic [11:0] v);
        start = 1'b1;
        bcd   = v;
        @(negedge clk);
        start = 1'b0;
        bcd   = 12'($urandom);
    endtask

    // Waits for done, pulsing start with 999 at edge counts pa/pb while busy.
    task automatic wait_done(input int pa, input int pb, output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            chk("busy_during_conv", busy, 1);
            if (n == pa || n == pb) begin
                start = 1'b1;
                bcd   = 12'h999;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
    endtask

    task automatic conv_check(input string tag, input logic [11:0] v, input int pa, input int pb);
        int n, eb, ee;
        model(v, eb, ee);
        start_conv(v);
        wait_done(pa, pb, n);
        chk({tag, "_latency"}, n, BIN_W);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_bin"}, bin, eb);
        chk({tag, "_err"}, err, ee);
    endtask

    task automatic check_quiet(input string tag, input int cycles, input int eb);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, "_no_done"}, done, 0);
            chk({tag, "_idle"}, busy, 0);
            chk({tag, "_bin_held"}, bin, eb);
        end
    endtask

    initial begin
        int t_prev;
        int n;
        logic [11:0] v;
        logic [11:0] seq [4];
        int exp_seq [4];

        rst   = 1'b1;
        start = 1'b0;
        bcd   = 12'h000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_busy", busy, 0);
            chk("reset_done", done, 0);
            chk("reset_bin", bin, 0);
            chk("reset_err", err, 0);
        end

        conv_check("bcd999", 12'h999, -1, -1);
        chk("bcd999_hex", bin, 10'h3E7);
        check_quiet("bcd999_hold", 3, 999);

        // Back-to-back: each start lands in the previous done cycle.
        seq[0] = 12'h000; seq[1] = 12'h042; seq[2] = 12'h100; seq[3] = 12'h509;
        exp_seq[0] = 0; exp_seq[1] = 42; exp_seq[2] = 100; exp_seq[3] = 509;
        @(negedge clk);
        t_prev = -1;
        for (int i = 0; i < 4; i++) begin
            start_conv(seq[i]);
            wait_done(-1, -1, n);
            chk("b2b_done", done, 1);
            chk("b2b_bin", bin, exp_seq[i]);
            chk("b2b_err", err, 0);
            if (t_prev >= 0) chk("b2b_spacing", cyc - t_prev, BIN_W + 1);
            t_prev = cyc;
        end
        check_quiet("b2b_tail", 2, 509);

        conv_check("bad_digit", 12'h1A5, -1, -1);
        @(negedge clk);
        conv_check("after_bad", 12'h007, -1, -1);

        // Starts while busy must be ignored.
        @(negedge clk);
        conv_check("ignore_start", 12'h321, 3, 7);
        check_quiet("ignore_tail", 15, 321);

        // Reset mid-conversion aborts with no done.
        start_conv(12'h888);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bin", bin, 0);
        chk("abort_err", err, 0);
        check_quiet("abort_tail", 15, 0);
        conv_check("fresh888", 12'h888, -1, -1);

        // Random conversions, mostly valid digits with occasional bad ones.
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < DIGITS; i++)
                v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                           : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            conv_check("random", v, -1, -1);
        end
        check_quiet("final", 3, bin);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
